i2c_slave_responder: RTL and testbench



---
 rtl/i2c_slave_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// Single-address I2C target: write bytes are strobed out, read bytes are fetched via tx_req_o/tx_valid_i.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low on a read underrun instead of returning 8'hFF.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_req_o,
  output logic       underrun_o,
  output logic       busy_o
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_DATA   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_now, sda_now, scl_last, sda_last;
  logic       scl_rise, scl_fall, start, stop;
  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shift, shift_in, tx_buf;
  logic       tx_have, rw, ack_phase, first, load_evt, hold;
`ifdef I2C_SLAVE_STRETCH_EN
  logic       stretch, rel;
  assign hold = stretch;
`else
  assign hold  = 1'b0;
  assign scl_o = 1'b1;
`endif

  // Synchronizer stage; idle bus level is high, so reset to 1 to avoid phantom edges
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_last <= 1'b1;
      sda_last <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_last <= scl_now;
      sda_last <= sda_now;
    end
  end

  // Event detection stage
  assign scl_now  = scl_sync[SYNC_STAGES-1];
  assign sda_now  = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_now & ~scl_last;
  assign scl_fall = ~scl_now & scl_last;
  assign start    = scl_now & scl_last & sda_last & ~sda_now;
  assign stop     = scl_now & scl_last & ~sda_last & sda_now;
  assign shift_in = {shift[6:0], sda_now};
  assign load_evt = scl_fall & ack_phase & (((state == ADDR_ACK) & rw) | (state == RD_ACK));

  // Protocol stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      tx_buf     <= 8'h00;
      tx_have    <= 1'b0;
      rw         <= 1'b0;
      ack_phase  <= 1'b0;
      first      <= 1'b0;
      sda_o      <= 1'b1;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      rx_first_o <= 1'b0;
      tx_req_o   <= 1'b0;
      underrun_o <= 1'b0;
      busy_o     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_o      <= 1'b1;
      stretch    <= 1'b0;
      rel        <= 1'b0;
`endif
    end else begin
      rx_valid_o <= 1'b0;
      rx_first_o <= 1'b0;
      underrun_o <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      if (rel) begin
        scl_o <= 1'b1;
        rel   <= 1'b0;
      end
`endif
      // An early handshake parks the byte until the load edge
      if (tx_req_o && tx_valid_i && !hold) begin
        tx_buf   <= tx_data_i;
        tx_have  <= 1'b1;
        tx_req_o <= 1'b0;
      end
      if (start) begin
        state     <= ADDR;
        bit_cnt   <= 4'd0;
        sda_o     <= 1'b1;
        busy_o    <= 1'b1;
        tx_req_o  <= 1'b0;
        tx_have   <= 1'b0;
        ack_phase <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_o     <= 1'b1;
        stretch   <= 1'b0;
        rel       <= 1'b0;
`endif
      end else if (stop) begin
        state    <= IDLE;
        sda_o    <= 1'b1;
        tx_req_o <= 1'b0;
        tx_have  <= 1'b0;
        busy_o   <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_o    <= 1'b1;
        stretch  <= 1'b0;
        rel      <= 1'b0;
      end else if (stretch) begin
        if (tx_valid_i) begin
          shift    <= {tx_data_i[6:0], 1'b0};
          sda_o    <= tx_data_i[7];
          tx_req_o <= 1'b0;
          stretch  <= 1'b0;
          rel      <= 1'b1;
        end
`endif
      end else if (load_evt) begin
        tx_have  <= 1'b0;
        tx_req_o <= 1'b0;
        bit_cnt  <= 4'd1;
        state    <= RD_DATA;
        if (tx_have) begin
          shift <= {tx_buf[6:0], 1'b0};
          sda_o <= tx_buf[7];
        end else if (tx_req_o && tx_valid_i) begin
          shift <= {tx_data_i[6:0], 1'b0};
          sda_o <= tx_data_i[7];
        end else begin
`ifdef I2C_SLAVE_STRETCH_EN
          scl_o    <= 1'b0;
          stretch  <= 1'b1;
          tx_req_o <= 1'b1;
          sda_o    <= 1'b1;
`else
          shift      <= 8'hFE;
          sda_o      <= 1'b1;
          underrun_o <= 1'b1;
`endif
        end
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift   <= shift_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                state     <= ADDR_ACK;
                rw        <= shift_in[0];
                ack_phase <= 1'b0;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise && ack_phase && rw) tx_req_o <= 1'b1;
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_o     <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                sda_o   <= 1'b1;
                state   <= WR_DATA;
                bit_cnt <= 4'd0;
                first   <= 1'b1;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            shift   <= shift_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data_o  <= shift_in;
              rx_valid_o <= 1'b1;
              rx_first_o <= first;
              first      <= 1'b0;
              state      <= WR_ACK;
              ack_phase  <= 1'b0;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_o     <= 1'b0;
              ack_phase <= 1'b1;
            end else begin
              sda_o   <= 1'b1;
              state   <= WR_DATA;
              bit_cnt <= 4'd0;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_o     <= 1'b1;
              state     <= RD_ACK;
              ack_phase <= 1'b0;
            end else begin
              sda_o   <= shift[7];
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD_ACK: if (scl_rise && !ack_phase) begin
            if (!sda_now) begin
              tx_req_o  <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              state <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: a bit-level I2C master drives an open-drain bus shared with the responder.
module tb_i2c_slave_responder;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_o, sda_o, rx_valid_o, rx_first_o, tx_req_o, underrun_o, busy_o;
  logic [7:0] rx_data_o;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  wire        scl_bus = scl_m & scl_o;
  wire        sda_bus = sda_m & sda_o;

  int checks = 0, errors = 0;
  int n_rx = 0, n_req = 0, n_under = 0;
  logic [7:0] last_rx = 8'h00;
  logic       last_first = 1'b0, req_d = 1'b0;

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_first_o(rx_first_o), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_req_o(tx_req_o), .underrun_o(underrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_d <= tx_req_o;
    if (rx_valid_o) begin
      n_rx       <= n_rx + 1;
      last_rx    <= rx_data_o;
      last_first <= rx_first_o;
    end
    if (tx_req_o && !req_d) n_req <= n_req + 1;
    if (underrun_o) n_under <= n_under + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl_bus !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (scl_bus !== 1'b1) begin
      checks++; errors++;
      $display("FAIL scl_timeout scl_bus=%b required 1", scl_bus);
    end
  endtask

  task automatic bus_bit(input logic b, output logic got);
    sda_m = b; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    got = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], g);
    bus_bit(1'b1, g);
    ack = ~g;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, g);
      d[i] = g;
    end
    bus_bit(~m_ack, g);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3);
    checks++; if (sda_o !== 1'b1 || scl_o !== 1'b1) begin errors++; $display("FAIL reset_lines sda=%b scl=%b required 1 1", sda_o, scl_o); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h required 00", rx_data_o); end
    checks++; if ({rx_valid_o, rx_first_o, tx_req_o, underrun_o, busy_o} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b required 00000", {rx_valid_o, rx_first_o, tx_req_o, underrun_o, busy_o}); end
    rst = 1'b0; tick(4);
  endtask

  task automatic test_write();
    logic ack; int rx0 = n_rx;
    bus_start();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy_start got %b required 1", busy_o); end
    send_byte({7'h22, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_addr_ack got %b required 1", ack); end
    send_byte(8'h44, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_data_ack got %b required 1", ack); end
    checks++; if (n_rx - rx0 != 1 || last_rx !== 8'h44 || last_first !== 1'b1) begin errors++; $display("FAIL wr_rx pulses=%0d data=%h first=%b required 1 44 1", n_rx - rx0, last_rx, last_first); end
    bus_stop();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b required 0", busy_o); end
  endtask

  task automatic test_wrong_addr();
    logic ack; int rx0 = n_rx;
    bus_start();
    send_byte({7'h23, 1'b0}, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL na_addr_ack got %b required 0", ack); end
    send_byte(8'h44, ack);
    checks++; if (ack !== 1'b0 || n_rx != rx0 || busy_o !== 1'b1) begin errors++; $display("FAIL na_ignore ack=%b pulses=%0d busy=%b required 0 0 1", ack, n_rx - rx0, busy_o); end
    bus_stop();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL na_busy_stop got %b required 0", busy_o); end
  endtask

  task automatic test_read();
    logic ack; logic [7:0] d; int rq0 = n_req;
    tx_data = 8'hA5; tx_valid = 1'b1;
    bus_start();
    send_byte({7'h22, 1'b1}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_ack got %b required 1", ack); end
    tx_data = 8'h5A;
    recv_byte(1'b1, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rd_byte0 got %b required 10100101", d); end
    recv_byte(1'b0, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rd_byte1 got %b required 01011010", d); end
    bus_stop();
    checks++; if (n_req - rq0 != 2 || tx_req_o !== 1'b0) begin errors++; $display("FAIL rd_req_count got %0d req=%b required 2 0", n_req - rq0, tx_req_o); end
    tx_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ack; logic [7:0] d; int rx0 = n_rx; int rq0 = n_req;
    bus_start();
    send_byte({7'h22, 1'b0}, ack);
    send_byte(8'h11, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rs_data_ack got %b required 1", ack); end
    tx_data = 8'h96; tx_valid = 1'b1;
    bus_start();
    checks++; if (n_rx - rx0 != 1 || last_rx !== 8'h11 || last_first !== 1'b1 || n_req != rq0) begin errors++; $display("FAIL rs_write pulses=%0d data=%h first=%b reqs=%0d required 1 11 1 0", n_rx - rx0, last_rx, last_first, n_req - rq0); end
    send_byte({7'h22, 1'b1}, ack);
    checks++; if (ack !== 1'b1 || n_req - rq0 != 1) begin errors++; $display("FAIL rs_read_addr ack=%b reqs=%0d required 1 1", ack, n_req - rq0); end
    recv_byte(1'b0, d);
    checks++; if (d !== 8'h96) begin errors++; $display("FAIL rs_read_byte got %h required 96", d); end
    bus_stop();
    tx_valid = 1'b0;
  endtask

  task automatic test_underrun();
    logic ack; logic [7:0] d; int un0 = n_under;
    tx_valid = 1'b0;
    bus_start();
    send_byte({7'h22, 1'b1}, ack);
`ifdef I2C_SLAVE_STRETCH_EN
    checks++; if (scl_o !== 1'b0 || tx_req_o !== 1'b1) begin errors++; $display("FAIL st_hold scl=%b req=%b required 0 1", scl_o, tx_req_o); end
    tick(30);
    checks++; if (scl_o !== 1'b0) begin errors++; $display("FAIL st_hold_long scl=%b required 0", scl_o); end
    tx_data = 8'h3C; tx_valid = 1'b1; tick(4);
    tx_valid = 1'b0;
    checks++; if (scl_o !== 1'b1 || tx_req_o !== 1'b0) begin errors++; $display("FAIL st_release scl=%b req=%b required 1 0", scl_o, tx_req_o); end
    recv_byte(1'b0, d);
    checks++; if (d !== 8'h3C || n_under != un0) begin errors++; $display("FAIL st_byte got %b underruns=%0d required 00111100 0", d, n_under - un0); end
`else
    recv_byte(1'b0, d);
    checks++; if (d !== 8'hFF || n_under - un0 != 1) begin errors++; $display("FAIL ur_byte got %b underruns=%0d required 11111111 1", d, n_under - un0); end
    checks++; if (tx_req_o !== 1'b0) begin errors++; $display("FAIL ur_req got %b required 0", tx_req_o); end
`endif
    bus_stop();
  endtask

  task automatic test_reset_mid();
    logic ack; logic g;
    tx_data = 8'hA5; tx_valid = 1'b1;
    bus_start();
    send_byte({7'h22, 1'b1}, ack);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, g);
    checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL rm_bit4 got %b required 0", sda_o); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (sda_o !== 1'b1 || scl_o !== 1'b1) begin errors++; $display("FAIL rm_release sda=%b scl=%b required 1 1", sda_o, scl_o); end
    checks++; if (rx_data_o !== 8'h00 || {rx_valid_o, rx_first_o, tx_req_o, underrun_o, busy_o} !== 5'b0) begin errors++; $display("FAIL rm_outputs data=%h flags=%b required 00 00000", rx_data_o, {rx_valid_o, rx_first_o, tx_req_o, underrun_o, busy_o}); end
    tick(2); rst = 1'b0; tx_valid = 1'b0;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    bus_start();
    send_byte({7'h22, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rm_readdr_ack got %b required 1", ack); end
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
